apb_fabric_mailbox: RTL and testbench

- APB3 slave that sits directly downstream of the MSS APB slave port (PSELS1/PENABLES/PADDRS/PWDATAS in, PRDATAS1/PREADYS1/PSLVERRS1 out).
- Provides a bidirectional word mailbox between the Cortex-M3 and the fabric soft processor:
  - m2f FIFO: M3 writes, fabric pops via valid/ready stream.
  - f2m FIFO: fabric pushes via stream, M3 reads.
- Status/control registers, sticky error flags, level interrupt to the M3.

---
 rtl/apb_fabric_mailbox.sv | 245 ++++++++++++++++++++++++
 tb/tb_apb_fabric_mailbox.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fabric_mailbox.sv
// APB3 slave mailbox between the Cortex-M3 and the fabric soft processor.
// Holds two word FIFOs (m2f, f2m), status/control registers, sticky error flags and a level irq.
module apb_fabric_mailbox #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [31:0] i_paddr,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr,
  output logic [31:0] o_m2f_data,
  output logic        o_m2f_valid,
  input  logic        i_m2f_ready,
  input  logic [31:0] i_f2m_data,
  input  logic        i_f2m_valid,
  output logic        o_f2m_ready,
  output logic        o_mbox_irq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_reg;
  logic        r_addrBad;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;
  logic        r_doPush;
  logic        r_doPop;
  logic        r_doCtrl;
  logic        r_setOvf;
  logic        r_setUdf;

  logic        r_ovf;
  logic        r_udf;
  logic        r_irqEn;
  logic        r_irq;

  logic [31:0] r_m2fMem [DEPTH];
  logic [PW-1:0] r_m2fRd;
  logic [PW-1:0] r_m2fWr;
  logic [CW-1:0] r_m2fCount;

  logic [31:0] r_f2mMem [DEPTH];
  logic [PW-1:0] r_f2mRd;
  logic [PW-1:0] r_f2mWr;
  logic [CW-1:0] r_f2mCount;

  logic        w_m2fFull;
  logic        w_m2fEmpty;
  logic        w_f2mFull;
  logic        w_f2mEmpty;
  logic        w_flush;
  logic        w_m2fPush;
  logic        w_m2fPop;
  logic        w_f2mPush;
  logic        w_f2mPop;
  logic        w_clrOvf;
  logic        w_clrUdf;
  logic [31:0] w_status;
  logic        w_unusedPaddr;

  assign w_unusedPaddr = ^{i_paddr[31:ADDR_W], i_paddr[1:0]};

  assign w_m2fFull  = (r_m2fCount == CW'(DEPTH));
  assign w_m2fEmpty = (r_m2fCount == '0);
  assign w_f2mFull  = (r_f2mCount == CW'(DEPTH));
  assign w_f2mEmpty = (r_f2mCount == '0);

  // Side effects are committed on the DONE cycle; the do* strobes only live in DONE.
  assign w_flush   = r_doCtrl & r_wdata[2];
  assign w_clrOvf  = r_doCtrl & r_wdata[0];
  assign w_clrUdf  = r_doCtrl & r_wdata[1];
  assign w_m2fPush = r_doPush;
  assign w_m2fPop  = o_m2f_valid & i_m2f_ready & ~w_flush;
  assign w_f2mPush = i_f2m_valid & o_f2m_ready & ~w_flush;
  assign w_f2mPop  = r_doPop & ~w_flush;

  assign w_status = {8'b0, 8'(r_f2mCount), 8'(r_m2fCount), 2'b0,
                     r_udf, r_ovf, w_f2mEmpty, w_f2mFull, w_m2fEmpty, w_m2fFull};

  assign o_prdata    = r_prdata;
  assign o_pready    = r_pready;
  assign o_pslverr   = r_pslverr;
  assign o_m2f_data  = r_m2fMem[r_m2fRd];
  assign o_m2f_valid = ~w_m2fEmpty;
  assign o_f2m_ready = ~w_f2mFull;
  assign o_mbox_irq  = r_irq;

  // The access is decoded on the WAIT->DONE edge so response and side effects agree.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_reg     <= '0;
      r_addrBad <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_doPush  <= 1'b0;
      r_doPop   <= 1'b0;
      r_doCtrl  <= 1'b0;
      r_setOvf  <= 1'b0;
      r_setUdf  <= 1'b0;
    end else begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_doPush  <= 1'b0;
      r_doPop   <= 1'b0;
      r_doCtrl  <= 1'b0;
      r_setOvf  <= 1'b0;
      r_setUdf  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_psel && i_penable) begin
            r_reg     <= i_paddr[3:2];
            r_addrBad <= |i_paddr[ADDR_W-1:4];
            r_write   <= i_pwrite;
            r_wdata   <= i_pwdata;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!i_psel) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_DONE;
            r_pready <= 1'b1;
            if (r_addrBad) begin
              r_pslverr <= 1'b1;
            end else begin
              case (r_reg)
                2'd0: begin
                  if (r_write) begin
                    if (w_m2fFull) begin
                      r_pslverr <= 1'b1;
                      r_setOvf  <= 1'b1;
                    end else begin
                      r_doPush <= 1'b1;
                    end
                  end
                end
                2'd1: begin
                  if (!r_write) begin
                    if (w_f2mEmpty) begin
                      r_pslverr <= 1'b1;
                      r_setUdf  <= 1'b1;
                    end else begin
                      r_prdata <= r_f2mMem[r_f2mRd];
                      r_doPop  <= 1'b1;
                    end
                  end
                end
                2'd2: begin
                  if (!r_write) r_prdata <= w_status;
                end
                default: begin
                  if (r_write) r_doCtrl <= 1'b1;
                  else         r_prdata <= {28'b0, r_irqEn, 3'b0};
                end
              endcase
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_m2fRd    <= '0;
      r_m2fWr    <= '0;
      r_m2fCount <= '0;
    end else if (w_flush) begin
      r_m2fRd    <= '0;
      r_m2fWr    <= '0;
      r_m2fCount <= '0;
    end else begin
      if (w_m2fPush) r_m2fWr <= r_m2fWr + 1'b1;
      if (w_m2fPop)  r_m2fRd <= r_m2fRd + 1'b1;
      r_m2fCount <= r_m2fCount + CW'(w_m2fPush) - CW'(w_m2fPop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_m2fPush) r_m2fMem[r_m2fWr] <= r_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_f2mRd    <= '0;
      r_f2mWr    <= '0;
      r_f2mCount <= '0;
    end else if (w_flush) begin
      r_f2mRd    <= '0;
      r_f2mWr    <= '0;
      r_f2mCount <= '0;
    end else begin
      if (w_f2mPush) r_f2mWr <= r_f2mWr + 1'b1;
      if (w_f2mPop)  r_f2mRd <= r_f2mRd + 1'b1;
      r_f2mCount <= r_f2mCount + CW'(w_f2mPush) - CW'(w_f2mPop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_f2mPush) r_f2mMem[r_f2mWr] <= i_f2m_data;
  end

  // Sticky flags hold until software clears them; irq lags its sources by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_irqEn <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_clrOvf)      r_ovf <= 1'b0;
      else if (r_setOvf) r_ovf <= 1'b1;
      if (w_clrUdf)      r_udf <= 1'b0;
      else if (r_setUdf) r_udf <= 1'b1;
      if (r_doCtrl)      r_irqEn <= r_wdata[3];
      r_irq <= r_irqEn & (~w_f2mEmpty | r_ovf);
    end
  end

endmodule

// File: tb/tb_apb_fabric_mailbox.sv
// Directed self-checking bench for apb_fabric_mailbox (DEPTH=16, ADDR_W=12).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_apb_fabric_mailbox;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] m2fData;
  logic        m2fValid;
  logic        m2fReady;
  logic [31:0] f2mData;
  logic        f2mValid;
  logic        f2mReady;
  logic        mboxIrq;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  apb_fabric_mailbox #(.DEPTH(16), .ADDR_W(12)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_psel      (psel),
    .i_penable   (penable),
    .i_pwrite    (pwrite),
    .i_paddr     (paddr),
    .i_pwdata    (pwdata),
    .o_prdata    (prdata),
    .o_pready    (pready),
    .o_pslverr   (pslverr),
    .o_m2f_data  (m2fData),
    .o_m2f_valid (m2fValid),
    .i_m2f_ready (m2fReady),
    .i_f2m_data  (f2mData),
    .i_f2m_valid (f2mValid),
    .o_f2m_ready (f2mReady),
    .o_mbox_irq  (mboxIrq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVec++;
    assert (observed === expected) else begin
      nMis++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'b0, observed}, {31'b0, expected});
  endtask

  // One full APB transfer; optionally raises f2m_valid on the DONE cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic pushInDone, input logic [31:0] pushWord,
                               output logic [31:0] rdata, output logic slverr, output int cycles);
    logic seen;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 10) begin
      cycles++;
      if (pready === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checkFlag("pready_seen", pready, 1'b1);
    rdata  = prdata;
    slverr = pslverr;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (pushInDone) begin
      f2mValid = 1'b1;
      f2mData  = pushWord;
    end
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data, input string tag, input logic expErr);
    logic [31:0] rd;
    logic        err;
    int          cyc;
    applyStimulus(1'b1, addr, data, 1'b0, 32'h0, rd, err, cyc);
    checkFlag({tag, "_pslverr"}, err, expErr);
  endtask

  task automatic apbRead(input logic [31:0] addr, input string tag, input logic [31:0] expData,
                         input logic expErr, output int cycles);
    logic [31:0] rd;
    logic        err;
    applyStimulus(1'b0, addr, 32'h0, 1'b0, 32'h0, rd, err, cycles);
    checkOutput({tag, "_prdata"}, rd, expData);
    checkFlag({tag, "_pslverr"}, err, expErr);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [31:0] rd;
    logic        err;

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; m2fReady = 1'b0; f2mData = '0; f2mValid = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_prdata", prdata, 32'h0);
    checkFlag("rst_pready", pready, 1'b0);
    checkFlag("rst_pslverr", pslverr, 1'b0);
    checkFlag("rst_m2f_valid", m2fValid, 1'b0);
    checkFlag("rst_f2m_ready", f2mReady, 1'b1);
    checkFlag("rst_irq", mboxIrq, 1'b0);
    reset = 1'b0;

    $display("[TB] status after reset and access latency");
    apbRead(32'h8, "status0", 32'h0000_000A, 1'b0, cyc);
    checkOutput("status0_cycles", cyc, 3);

    $display("[TB] m2f write and fabric drain");
    apbWrite(32'h0, 32'hDEAD_BEEF, "tx0", 1'b0);
    apbWrite(32'h0, 32'h1234_5678, "tx1", 1'b0);
    apbRead(32'h8, "status1", 32'h0000_0208, 1'b0, cyc);
    checkFlag("m2f_valid_2", m2fValid, 1'b1);
    checkOutput("m2f_head0", m2fData, 32'hDEAD_BEEF);
    m2fReady = 1'b1;
    @(negedge clk);
    checkFlag("m2f_valid_1", m2fValid, 1'b1);
    checkOutput("m2f_head1", m2fData, 32'h1234_5678);
    @(negedge clk);
    checkFlag("m2f_valid_0", m2fValid, 1'b0);
    m2fReady = 1'b0;

    $display("[TB] fill f2m from fabric");
    @(negedge clk);
    f2mValid = 1'b1;
    f2mData  = 32'hA000_0000;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      f2mData = 32'hA000_0000 + i;
    end
    @(negedge clk);
    f2mData = 32'hBAD0_BAD0;
    checkFlag("f2m_ready_full", f2mReady, 1'b0);
    repeat (2) @(negedge clk);
    f2mValid = 1'b0;
    apbRead(32'h8, "status_f2m_full", 32'h0010_0006, 1'b0, cyc);

    $display("[TB] drain f2m over APB");
    for (int i = 0; i < 16; i++) begin
      apbRead(32'h4, $sformatf("rx_%0d", i), 32'hA000_0000 + i, 1'b0, cyc);
    end
    apbRead(32'h4, "rx_underflow", 32'h0, 1'b1, cyc);
    apbRead(32'h8, "status_udf", 32'h0000_002A, 1'b0, cyc);

    $display("[TB] m2f overflow and irq");
    for (int i = 0; i < 16; i++) begin
      apbWrite(32'h0, 32'hC000_0000 + i, $sformatf("fill_%0d", i), 1'b0);
    end
    apbWrite(32'h0, 32'hFFFF_FFFF, "tx_overflow", 1'b1);
    apbRead(32'h8, "status_ovf", 32'h0000_1039, 1'b0, cyc);
    checkOutput("m2f_head_after_ovf", m2fData, 32'hC000_0000);
    apbWrite(32'hC, 32'h8, "ctrl_irq_en", 1'b0);
    repeat (2) @(negedge clk);
    checkFlag("irq_ovf", mboxIrq, 1'b1);
    apbRead(32'hC, "ctrl_read", 32'h0000_0008, 1'b0, cyc);
    apbWrite(32'hC, 32'h9, "ctrl_clr_ovf", 1'b0);
    repeat (2) @(negedge clk);
    checkFlag("irq_cleared", mboxIrq, 1'b0);
    apbRead(32'h8, "status_ovf_clr", 32'h0000_1029, 1'b0, cyc);

    $display("[TB] bad address");
    apbRead(32'h10, "bad_addr", 32'h0, 1'b1, cyc);
    apbRead(32'h8, "status_after_bad", 32'h0000_1029, 1'b0, cyc);

    $display("[TB] flush with concurrent fabric push");
    @(negedge clk);
    f2mValid = 1'b1;
    f2mData  = 32'h0000_0011;
    @(negedge clk);
    f2mData  = 32'h0000_0022;
    @(negedge clk);
    f2mValid = 1'b0;
    repeat (2) @(negedge clk);
    checkFlag("irq_f2m_nonempty", mboxIrq, 1'b1);
    applyStimulus(1'b1, 32'hC, 32'hC, 1'b1, 32'h5A5A_5A5A, rd, err, cyc);
    checkFlag("flush_pslverr", err, 1'b0);
    @(negedge clk);
    f2mValid = 1'b0;
    checkFlag("flush_m2f_valid", m2fValid, 1'b0);
    checkFlag("flush_f2m_ready", f2mReady, 1'b1);
    apbRead(32'h8, "status_flush", 32'h0000_002A, 1'b0, cyc);
    checkFlag("irq_after_flush", mboxIrq, 1'b0);

    $display("[TB] reset during WAIT of a TX write");
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h7777_7777;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    checkFlag("midrst_wait_pready", pready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    checkFlag("midrst_pready", pready, 1'b0);
    checkFlag("midrst_m2f_valid", m2fValid, 1'b0);
    checkFlag("midrst_f2m_ready", f2mReady, 1'b1);
    checkOutput("midrst_prdata", prdata, 32'h0);
    checkFlag("midrst_irq", mboxIrq, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkFlag("postrst_pready", pready, 1'b0);
    checkFlag("postrst_m2f_valid", m2fValid, 1'b0);
    apbRead(32'h8, "status_postrst", 32'h0000_000A, 1'b0, cyc);
    apbRead(32'hC, "ctrl_postrst", 32'h0, 1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
